// File: rtl/micro_sequencer_pkg.sv
// Shared constants, field encodings and state type for the micro-sequencer.
package micro_sequencer_pkg;

  // Micro-PC width and the two fixed micro-addresses.
  localparam int              UPC_W      = 8;
  localparam logic [UPC_W-1:0] FETCH_ADDR = 8'h00;
  localparam logic [UPC_W-1:0] TRAP_ADDR  = 8'hFF;

  // Next-address control field of a microinstruction.
  localparam logic [1:0] SEQ_SEQ   = 2'b00;
  localparam logic [1:0] SEQ_DISP  = 2'b01;
  localparam logic [1:0] SEQ_FETCH = 2'b10;
  localparam logic [1:0] SEQ_BR    = 2'b11;

  // Opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Entry points of the execute routines in the control store.
  localparam logic [UPC_W-1:0] ADDR_ADD  = 8'h10;
  localparam logic [UPC_W-1:0] ADDR_SUB  = 8'h14;
  localparam logic [UPC_W-1:0] ADDR_AND  = 8'h18;
  localparam logic [UPC_W-1:0] ADDR_OR   = 8'h1C;
  localparam logic [UPC_W-1:0] ADDR_SLT  = 8'h20;
  localparam logic [UPC_W-1:0] ADDR_LW   = 8'h30;
  localparam logic [UPC_W-1:0] ADDR_SW   = 8'h38;
  localparam logic [UPC_W-1:0] ADDR_BEQ  = 8'h40;
  localparam logic [UPC_W-1:0] ADDR_J    = 8'h48;
  localparam logic [UPC_W-1:0] ADDR_ADDI = 8'h50;

  // Sequencer operating state.
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TRAP = 2'b10
  } state_t;

endpackage

// File: rtl/dispatch_rom.sv
// Combinational opcode/funct decoder giving the control-store entry point of
// each supported instruction; o_valid is low for unsupported encodings.
module dispatch_rom
  import micro_sequencer_pkg::*;
(
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_funct,
  output logic [UPC_W-1:0] o_addr,
  output logic             o_valid
);

  // Decode table; unlisted encodings fall through to the invalid defaults.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_addr  = TRAP_ADDR;
    o_valid = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD: begin o_addr = ADDR_ADD; o_valid = 1'b1; end
          FN_SUB: begin o_addr = ADDR_SUB; o_valid = 1'b1; end
          FN_AND: begin o_addr = ADDR_AND; o_valid = 1'b1; end
          FN_OR:  begin o_addr = ADDR_OR;  o_valid = 1'b1; end
          FN_SLT: begin o_addr = ADDR_SLT; o_valid = 1'b1; end
          default: ;
        endcase
      end
      OP_LW:   begin o_addr = ADDR_LW;   o_valid = 1'b1; end
      OP_SW:   begin o_addr = ADDR_SW;   o_valid = 1'b1; end
      OP_BEQ:  begin o_addr = ADDR_BEQ;  o_valid = 1'b1; end
      OP_J:    begin o_addr = ADDR_J;    o_valid = 1'b1; end
      OP_ADDI: begin o_addr = ADDR_ADDI; o_valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address sequencer for the microprogrammed control unit: micro-PC
// register, next-address mux, RUN/HALT/TRAP control and a per-instruction
// cycle counter.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_funct,
  input  logic [1:0]       i_seq,
  input  logic [UPC_W-1:0] i_target,
  input  logic             i_wait,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic [UPC_W-1:0] o_upc,
  output logic             o_fetch,
  output logic             o_instr_done,
  output logic             o_illegal,
  output logic             o_halted,
  output logic [7:0]       o_ucycle
);

  state_t           state, state_n;
  logic [UPC_W-1:0] upc_n;
  logic [7:0]       ucycle_n;
  logic [UPC_W-1:0] disp_addr;
  logic             disp_valid;
  logic             retire;

  dispatch_rom u_dispatch_rom (
    .i_op    (i_op),
    .i_funct (i_funct),
    .o_addr  (disp_addr),
    .o_valid (disp_valid)
  );

  // An instruction retires when its FETCH microinstruction completes unstalled.
  assign retire       = (state == ST_RUN) && (i_seq == SEQ_FETCH) && !i_wait;
  assign o_instr_done = retire;
  assign o_fetch      = (state == ST_RUN) && (o_upc == FETCH_ADDR);

  // Next-state, next micro-PC and cycle-count selection.
  always_comb begin
    state_n  = state;
    upc_n    = o_upc;
    ucycle_n = o_ucycle;
    case (state)
      ST_RUN: begin
        // Stall cycles count too; the counter only clears on retirement.
        ucycle_n = (o_ucycle == 8'hFF) ? o_ucycle : o_ucycle + 8'd1;
        if (!i_wait) begin
          case (i_seq)
            SEQ_SEQ:  upc_n = o_upc + UPC_W'(1);
            SEQ_DISP: begin
              if (disp_valid) begin
                upc_n = disp_addr;
              end else begin
                upc_n   = TRAP_ADDR;
                state_n = ST_TRAP;
              end
            end
            SEQ_FETCH: begin
              upc_n    = FETCH_ADDR;
              ucycle_n = 8'd0;
              if (i_halt_req) state_n = ST_HALT;
            end
            default:  upc_n = i_target;
          endcase
        end
      end
      ST_HALT: begin
        upc_n = FETCH_ADDR;
        if (i_resume) begin
          state_n  = ST_RUN;
          ucycle_n = 8'd0;
        end
      end
      ST_TRAP: upc_n = TRAP_ADDR;
      default: begin
        state_n  = ST_RUN;
        upc_n    = FETCH_ADDR;
        ucycle_n = 8'd0;
      end
    endcase
  end

  // State, micro-PC, counter and status flags, all asynchronously reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_RUN;
      o_upc     <= FETCH_ADDR;
      o_ucycle  <= 8'd0;
      o_illegal <= 1'b0;
      o_halted  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      o_upc     <= upc_n;
      o_ucycle  <= ucycle_n;
      o_illegal <= (state_n == ST_TRAP);
      o_halted  <= (state_n == ST_HALT);
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer.
module tb_micro_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [5:0] i_op;
  logic [5:0] i_funct;
  logic [1:0] i_seq;
  logic [7:0] i_target;
  logic       i_wait;
  logic       i_halt_req;
  logic       i_resume;
  logic [7:0] o_upc;
  logic       o_fetch;
  logic       o_instr_done;
  logic       o_illegal;
  logic       o_halted;
  logic [7:0] o_ucycle;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_op         (i_op),
    .i_funct      (i_funct),
    .i_seq        (i_seq),
    .i_target     (i_target),
    .i_wait       (i_wait),
    .i_halt_req   (i_halt_req),
    .i_resume     (i_resume),
    .o_upc        (o_upc),
    .o_fetch      (o_fetch),
    .o_instr_done (o_instr_done),
    .o_illegal    (o_illegal),
    .o_halted     (o_halted),
    .o_ucycle     (o_ucycle)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [1:0] seq, input logic wt, input logic hreq, input logic res);
    i_seq      = seq;
    i_wait     = wt;
    i_halt_req = hreq;
    i_resume   = res;
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1'b1;
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_op = 6'd0; i_funct = 6'd0; i_seq = 2'b00; i_target = 8'h00;
    i_wait = 1'b0; i_halt_req = 1'b0; i_resume = 1'b0;
    step(2);
    check("rst_upc", o_upc, 8'h00);
    check("rst_ucycle", o_ucycle, 8'd0);
    check("rst_illegal", o_illegal, 1'b0);
    check("rst_halted", o_halted, 1'b0);
    check("rst_fetch", o_fetch, 1'b1);
    i_rst = 1'b0;

    // Sequential stepping.
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    check("seq_done0", o_instr_done, 1'b0);
    step();
    check("seq_upc1", o_upc, 8'h01);
    check("seq_fetch1", o_fetch, 1'b0);
    step();
    check("seq_upc2", o_upc, 8'h02);
    step();
    check("seq_upc3", o_upc, 8'h03);
    check("seq_ucycle3", o_ucycle, 8'd3);

    // Retire, then dispatch SUB.
    set_in(2'b10, 1'b0, 1'b0, 1'b0);
    check("ret_done", o_instr_done, 1'b1);
    step();
    check("ret_upc", o_upc, 8'h00);
    check("ret_ucycle", o_ucycle, 8'd0);
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    i_op = 6'b000000; i_funct = 6'b100010;
    set_in(2'b01, 1'b0, 1'b0, 1'b0);
    step();
    check("disp_sub", o_upc, 8'h14);
    check("disp_sub_ucycle", o_ucycle, 8'd2);

    // Retire, then dispatch LW.
    set_in(2'b10, 1'b0, 1'b0, 1'b0);
    step();
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    i_op = 6'b100011; i_funct = 6'b111111;
    set_in(2'b01, 1'b0, 1'b0, 1'b0);
    step();
    check("disp_lw", o_upc, 8'h30);

    // Memory wait on the FETCH microinstruction.
    set_in(2'b10, 1'b1, 1'b0, 1'b0);
    check("wait_done0", o_instr_done, 1'b0);
    step(3);
    check("wait_upc", o_upc, 8'h30);
    check("wait_ucycle", o_ucycle, 8'd5);
    check("wait_done1", o_instr_done, 1'b0);
    set_in(2'b10, 1'b0, 1'b0, 1'b0);
    check("wait_rel_done", o_instr_done, 1'b1);
    step();
    check("wait_rel_upc", o_upc, 8'h00);
    check("wait_rel_ucycle", o_ucycle, 8'd0);

    // Halt request: ignored on SEQ, taken on FETCH.
    set_in(2'b00, 1'b0, 1'b1, 1'b0);
    step();
    check("hreq_seq_halted", o_halted, 1'b0);
    check("hreq_seq_upc", o_upc, 8'h01);
    set_in(2'b10, 1'b0, 1'b1, 1'b0);
    step();
    check("halt_halted", o_halted, 1'b1);
    check("halt_upc", o_upc, 8'h00);
    check("halt_fetch", o_fetch, 1'b0);
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    check("halt_done", o_instr_done, 1'b0);
    step(2);
    check("halt_hold_upc", o_upc, 8'h00);
    check("halt_hold_ucycle", o_ucycle, 8'd0);
    set_in(2'b00, 1'b0, 1'b0, 1'b1);
    step();
    check("resume_halted", o_halted, 1'b0);
    check("resume_fetch", o_fetch, 1'b1);

    // Resume outside HALT is ignored; branch to 0xFF, then wrap.
    i_target = 8'hFF;
    set_in(2'b11, 1'b0, 1'b0, 1'b1);
    step();
    check("br_upc", o_upc, 8'hFF);
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    check("wrap_upc", o_upc, 8'h00);
    check("wrap_illegal", o_illegal, 1'b0);
    check("wrap_ucycle", o_ucycle, 8'd2);
    step();
    check("pre_stall_upc", o_upc, 8'h01);

    // Long stall saturates the cycle counter; reset mid-stall.
    set_in(2'b00, 1'b1, 1'b0, 1'b0);
    step(300);
    check("sat_ucycle", o_ucycle, 8'd255);
    check("sat_upc", o_upc, 8'h01);
    i_rst = 1'b1;
    #1;
    check("midrst_upc", o_upc, 8'h00);
    check("midrst_ucycle", o_ucycle, 8'd0);
    check("midrst_fetch", o_fetch, 1'b1);
    i_rst = 1'b0;
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    check("postrst_upc", o_upc, 8'h01);

    // Illegal opcode traps; only reset leaves TRAP.
    i_op = 6'b111111;
    set_in(2'b01, 1'b0, 1'b0, 1'b0);
    step();
    check("trap_upc", o_upc, 8'hFF);
    check("trap_illegal", o_illegal, 1'b1);
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    check("trap_seq_upc", o_upc, 8'hFF);
    set_in(2'b10, 1'b0, 1'b1, 1'b0);
    check("trap_done", o_instr_done, 1'b0);
    step();
    check("trap_fetch_upc", o_upc, 8'hFF);
    check("trap_halted", o_halted, 1'b0);
    set_in(2'b00, 1'b0, 1'b0, 1'b1);
    step();
    check("trap_resume_upc", o_upc, 8'hFF);
    check("trap_resume_illegal", o_illegal, 1'b1);
    check("trap_ucycle", o_ucycle, 8'd2);
    do_reset();
    check("trap_rst_upc", o_upc, 8'h00);
    check("trap_rst_illegal", o_illegal, 1'b0);

    // Invalid funct under the R-type opcode also traps.
    set_in(2'b00, 1'b0, 1'b0, 1'b0);
    step();
    i_op = 6'b000000; i_funct = 6'b000001;
    set_in(2'b01, 1'b0, 1'b0, 1'b0);
    step();
    check("trap_funct_upc", o_upc, 8'hFF);
    check("trap_funct_illegal", o_illegal, 1'b1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
